out_skid_stage: RTL and testbench

//  Registered 2-entry skid stage consuming the buffered "out" net of the top-level load-buffer tree.

---
 rtl/out_skid_pkg.sv | 12 +
 rtl/out_skid_stage.sv | 92 +++++++++
 tb/tb_out_skid_stage.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/out_skid_pkg.sv
// Shared types and defaults for the output skid stage.
package out_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/out_skid_stage.sv
// Two-entry registered skid stage: full throughput, with in_ready and out_valid
// driven straight from flops so no combinational path crosses the stage.
module out_skid_stage
  import out_skid_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] beat_cnt,
  output logic             ovf_err
);

  skid_state_e      state;
  logic [WIDTH-1:0] skid_p0;
  logic             accept;
  logic             emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // out_data is the main register; skid_p0 catches the beat that arrives
  // while the main register is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_p0   <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_data <= in_data;
          end else if (accept) begin
            skid_p0  <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_data <= skid_p0;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
    end else if (accept) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end

  // Sticky: upstream tried to change data while we were refusing it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_err <= 1'b0;
    end else if (in_valid && !in_ready && (in_data != skid_p0)) begin
      ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_skid_stage.sv
// Directed bench for out_skid_stage with a queue-based scoreboard on the output handshake.
module tb_out_skid_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [0:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [0:0] out_data;
  logic       out_ready;
  logic [7:0] beat_cnt;
  logic       ovf_err;

  logic       in_valid2;
  logic [0:0] in_data2;
  logic       in_ready2;
  logic       out_valid2;
  logic [0:0] out_data2;
  logic       out_ready2;
  logic [1:0] beat_cnt2;
  logic       ovf_err2;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] sb_q[$];

  out_skid_stage #(.WIDTH(1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .beat_cnt(beat_cnt), .ovf_err(ovf_err)
  );

  out_skid_stage #(.WIDTH(1), .CNT_W(2)) dut_wrap (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ready(out_ready2),
    .beat_cnt(beat_cnt2), .ovf_err(ovf_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshakes sampled mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          check("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) sb_q.push_back(in_data);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:0] pat4 [5];
    pat4[0] = 1'b0; pat4[1] = 1'b1; pat4[2] = 1'b1; pat4[3] = 1'b0; pat4[4] = 1'b1;

    rst_n = 1'b1;
    in_valid = 0; in_data = 0; out_ready = 0;
    in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("rst_ovf_err", 32'(ovf_err), 32'd0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    // Streaming 1,0,1,... with downstream always ready
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_data = (i % 2 == 0) ? 1'b1 : 1'b0;
      cyc();
      if (i == 0) begin
        check("stream_latency_valid", 32'(out_valid), 32'd1);
        check("stream_latency_data", 32'(out_data), 32'd1);
      end
      check("stream_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 0;
    cyc();
    check("stream_drained", 32'(out_valid), 32'd0);
    check("stream_beat_cnt", 32'(beat_cnt), 32'd10);

    // Backpressure: 1 then 0 with downstream stalled
    out_ready = 0;
    in_valid = 1; in_data = 1; cyc();
    in_data = 0; cyc();
    in_valid = 0;
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    check("bp_full_out_valid", 32'(out_valid), 32'd1);
    check("bp_full_out_data", 32'(out_data), 32'd1);
    cyc();
    check("bp_hold_out_data", 32'(out_data), 32'd1);
    check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1; cyc();
    check("bp_rel_out_data", 32'(out_data), 32'd0);
    check("bp_rel_in_ready", 32'(in_ready), 32'd1);
    cyc();
    check("bp_rel_empty", 32'(out_valid), 32'd0);
    check("bp_beat_cnt", 32'(beat_cnt), 32'd12);

    // Accept and emit together in ONE, no bubbles
    in_valid = 1; in_data = 1; cyc();
    for (int i = 0; i < 5; i++) begin
      in_data = pat4[i];
      cyc();
      check("ae_out_valid", 32'(out_valid), 32'd1);
      check("ae_in_ready", 32'(in_ready), 32'd1);
      check("ae_out_data", 32'(out_data), 32'(pat4[i]));
    end
    in_valid = 0; cyc(); cyc();
    check("ae_empty", 32'(out_valid), 32'd0);
    check("ae_beat_cnt", 32'(beat_cnt), 32'd18);

    // Overflow detection in FULL with skid holding 0
    out_ready = 0;
    in_valid = 1; in_data = 1; cyc();
    in_data = 0; cyc();
    check("ovf_pre", 32'(ovf_err), 32'd0);
    cyc();
    check("ovf_same_data", 32'(ovf_err), 32'd0);
    in_data = 1; cyc();
    check("ovf_set", 32'(ovf_err), 32'd1);
    in_valid = 0; out_ready = 1; cyc(); cyc();
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("ovf_drained", 32'(out_valid), 32'd0);
    check("ovf_beat_cnt", 32'(beat_cnt), 32'd20);

    // Asynchronous reset while FULL
    out_ready = 0;
    in_valid = 1; in_data = 1; cyc();
    in_data = 1; cyc();
    in_valid = 0;
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_beat_cnt", 32'(beat_cnt), 32'd0);
    check("midrst_ovf_err", 32'(ovf_err), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'd0);
    sb_q.delete();
    cyc();
    rst_n = 1'b1;
    cyc();
    check("post_rst_empty", 32'(out_valid), 32'd0);

    // Tie-low data passes as ordinary zero beats
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_data = 0; cyc();
      check("zero_out_valid", 32'(out_valid), 32'd1);
      check("zero_out_data", 32'(out_data), 32'd0);
    end
    in_valid = 0; cyc();
    check("zero_beat_cnt", 32'(beat_cnt), 32'd3);
    check("zero_drained", 32'(out_valid), 32'd0);

    // Counter wrap on the 2-bit instance
    out_ready2 = 1; in_valid2 = 1; in_data2 = 0;
    for (int i = 0; i < 5; i++) begin
      logic [1:0] exp_w;
      exp_w = (i == 0) ? 2'd1 : (i == 1) ? 2'd2 : (i == 2) ? 2'd3 : (i == 3) ? 2'd0 : 2'd1;
      cyc();
      check("wrap_beat_cnt", 32'(beat_cnt2), 32'(exp_w));
    end
    in_valid2 = 0; cyc();

    check("sb_empty_at_end", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
